uart_regfile_ctrl: RTL and testbench
====================================

Name: uart_regfile_ctrl

Overview:
Parametrised command controller between the chip's UART receiver/transmitter pair and the configuration register file. It unloads received packets, checks parity and address range, and writes the register file. Read commands are answered with a reply packet through the transmitter. Register count, data width and address width are generic, and it adds error counters and an optional write-echo mode. It is the next-generation replacement for the fixed 32x8 regfile path inside digital_core.

Parameters:
NUMREGS, 32, number of implemented registers (1..2**ADDR_WIDTH)
DATA_WIDTH, 8, bits per register
ADDR_WIDTH, 8, address field width
REG_DEFAULTS, all zeros, flattened NUMREGS*DATA_WIDTH reset values; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
ECHO_WRITES, 0, 1 = send a reply packet after each successful write
PKT_WIDTH, ADDR_WIDTH+DATA_WIDTH+2, derived packet width; do not override

Ports:
clk  input  1  system clock; rx/tx blocks share this clock
reset_n  input  1  asynchronous, active-low reset
rx_data  input  PKT_WIDTH  packet from uart_rx; valid the cycle after uld_rx_data is high
rx_empty  input  1  low = uart_rx holds an unread packet
uld_rx_data  output  1  one-cycle unload strobe to uart_rx
tx_data  output  PKT_WIDTH  reply packet to uart_tx
ld_tx_data  output  1  load request to uart_tx
tx_busy  input  1  uart_tx serialising
config_bits  output  NUMREGS*DATA_WIDTH  flattened register contents
parity_err_cnt  output  8  saturating count of parity-failed packets
addr_err_cnt  output  8  saturating count of out-of-range addresses
busy  output  1  high whenever FSM is not IDLE

Behaviour:
- Packet format, MSB to LSB: parity, addr[ADDR_WIDTH], data[DATA_WIDTH], wrb. wrb=0 write, wrb=1 read.
- Parity: odd over all PKT_WIDTH bits (total count of ones must be odd).
- Reset (async assert, sync release): state=IDLE; config_bits=REG_DEFAULTS; both counters=0; uld_rx_data=0; ld_tx_data=0; tx_data=0; busy=0.
- FSM states: IDLE, UNLOAD, CAPTURE, EXEC, TX_WAIT, TX_LOAD.
  - IDLE: rx_empty sampled low -> UNLOAD.
  - UNLOAD: uld_rx_data=1 for exactly this cycle -> CAPTURE.
  - CAPTURE: register rx_data into an internal packet register -> EXEC.
  - EXEC, parity bad: increment parity_err_cnt, no write, no reply -> IDLE.
  - EXEC, parity ok, addr >= NUMREGS: increment addr_err_cnt, no write, no reply -> IDLE.
  - EXEC, valid write: config_bits[addr] <= data; -> TX_WAIT if ECHO_WRITES=1, else IDLE.
  - EXEC, valid read: -> TX_WAIT.
  - TX_WAIT: build tx_data = {parity, addr, config_bits[addr], wrb}, with parity recomputed for odd parity and the original wrb. -> TX_LOAD when tx_busy=0.
  - TX_LOAD: hold ld_tx_data=1 and tx_data stable until tx_busy sampled 1, then drop ld_tx_data -> IDLE.
- Write echo returns the newly written value.
- Latency: with rx_empty low at edge k, uld_rx_data is high in cycle k+1. config_bits update is visible after edge k+3. For a read with tx idle, ld_tx_data rises after edge k+4.
- Precedence and boundaries:
  - Only IDLE samples rx_empty. Packets arriving during a reply stay in uart_rx and are processed in order afterwards.
  - Minimum spacing between back-to-back packets is 4 cycles for writes without echo.
  - Counters saturate at 255; no wrap.
  - Parity failure takes precedence over address error; only one counter increments per packet.
  - addr = NUMREGS-1 is valid. addr = NUMREGS through 2**ADDR_WIDTH-1 are errors.
  - reset_n low in any state returns everything to reset values immediately, including mid-TX_LOAD, and aborts the reply.
  - tx_busy already high on entry to TX_WAIT: remain in TX_WAIT; no lost or duplicated loads.
  - Exactly one ld_tx_data assertion episode per reply.

Test Plan:
- Write addr 0x01 data 0xAB, wrb=0, correct parity; ECHO_WRITES=0 -> register 1 = 0xAB after edge k+3; ld_tx_data never asserts; counters stay 0.
- Read addr 0x01 after the write -> one reply with addr=0x01, data=0xAB, wrb=1, correct odd parity. Also check that register 0x1F (NUMREGS-1) reads back REG_DEFAULTS.
- Write addr 0x05 data 0x3C with parity bit inverted -> register 5 unchanged; parity_err_cnt=1; no reply.
- Write and read addr 0x20 (NUMREGS=32) -> no register changes; addr_err_cnt=2; no reply.
- Hold tx_busy high for 50 cycles during a read reply while a second write is queued -> ld_tx_data held until tx_busy observed; second write applied only after reply completes; no lost packets.
- Random 100-op write/read sequence against a scoreboard. Then pulse reset_n low during TX_LOAD -> config_bits return to REG_DEFAULTS, ld_tx_data=0, FSM IDLE. Then send 300 bad-parity packets -> parity_err_cnt=255.

Source files
------------

// File: rtl/uart_regfile_ctrl.sv
// Command controller between uart_rx/uart_tx and the configuration register file.
// Unloads packets, checks odd parity and address range, writes registers and answers reads.
module uart_regfile_ctrl #(
    parameter int unsigned NUMREGS = 32,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [NUMREGS*DATA_WIDTH-1:0] REG_DEFAULTS = '0,
    parameter logic ECHO_WRITES = 1'b0,
    parameter int unsigned PKT_WIDTH = ADDR_WIDTH + DATA_WIDTH + 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [PKT_WIDTH-1:0]          rx_data,
    input  logic                          rx_empty,
    output logic                          uld_rx_data,
    output logic [PKT_WIDTH-1:0]          tx_data,
    output logic                          ld_tx_data,
    input  logic                          tx_busy,
    output logic [NUMREGS*DATA_WIDTH-1:0] config_bits,
    output logic [7:0]                    parity_err_cnt,
    output logic [7:0]                    addr_err_cnt,
    output logic                          busy
);

    localparam int unsigned IDX_W = (NUMREGS > 1) ? $clog2(NUMREGS) : 1;
    localparam logic [ADDR_WIDTH:0] NUMREGS_W = (ADDR_WIDTH + 1)'(NUMREGS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNLOAD,
        S_CAPTURE,
        S_EXEC,
        S_TX_WAIT,
        S_TX_LOAD
    } state_t;

    state_t                  state_q, state_d;
    logic [PKT_WIDTH-1:0]    pkt_q, pkt_d;
    logic [PKT_WIDTH-1:0]    tx_data_q, tx_data_d;
    logic                    ld_tx_q, ld_tx_d;
    logic [7:0]              par_cnt_q, par_cnt_d;
    logic [7:0]              addr_cnt_q, addr_cnt_d;
    logic [DATA_WIDTH-1:0]   regs_q [NUMREGS];
    logic [DATA_WIDTH-1:0]   regs_d [NUMREGS];

    logic                    pkt_wrb;
    logic [DATA_WIDTH-1:0]   pkt_data;
    logic [ADDR_WIDTH-1:0]   pkt_addr;
    logic [IDX_W-1:0]        pkt_idx;
    logic                    parity_ok;
    logic                    addr_ok;
    logic [PKT_WIDTH-2:0]    reply_body;

    assign pkt_wrb    = pkt_q[0];
    assign pkt_data   = pkt_q[DATA_WIDTH:1];
    assign pkt_addr   = pkt_q[PKT_WIDTH-2 -: ADDR_WIDTH];
    assign pkt_idx    = pkt_addr[IDX_W-1:0];
    assign parity_ok  = ^pkt_q;
    assign addr_ok    = ({1'b0, pkt_addr} < NUMREGS_W);
    // Reply reads the register after any write has landed, so echo returns the new value.
    assign reply_body = {pkt_addr, regs_q[pkt_idx], pkt_wrb};

    always_comb begin
        state_d    = state_q;
        pkt_d      = pkt_q;
        tx_data_d  = tx_data_q;
        ld_tx_d    = ld_tx_q;
        par_cnt_d  = par_cnt_q;
        addr_cnt_d = addr_cnt_q;
        regs_d     = regs_q;
        case (state_q)
            S_IDLE: begin
                if (!rx_empty) state_d = S_UNLOAD;
            end
            S_UNLOAD: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                pkt_d   = rx_data;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (!parity_ok) begin
                    if (par_cnt_q != '1) par_cnt_d = par_cnt_q + 8'd1;
                    state_d = S_IDLE;
                end else if (!addr_ok) begin
                    if (addr_cnt_q != '1) addr_cnt_d = addr_cnt_q + 8'd1;
                    state_d = S_IDLE;
                end else if (!pkt_wrb) begin
                    regs_d[pkt_idx] = pkt_data;
                    state_d = ECHO_WRITES ? S_TX_WAIT : S_IDLE;
                end else begin
                    state_d = S_TX_WAIT;
                end
            end
            S_TX_WAIT: begin
                tx_data_d = {~^reply_body, reply_body};
                if (!tx_busy) begin
                    ld_tx_d = 1'b1;
                    state_d = S_TX_LOAD;
                end
            end
            S_TX_LOAD: begin
                if (tx_busy) begin
                    ld_tx_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                ld_tx_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            pkt_q      <= '0;
            tx_data_q  <= '0;
            ld_tx_q    <= 1'b0;
            par_cnt_q  <= '0;
            addr_cnt_q <= '0;
            for (int unsigned i = 0; i < NUMREGS; i++) begin
                regs_q[i] <= REG_DEFAULTS[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end else begin
            state_q    <= state_d;
            pkt_q      <= pkt_d;
            tx_data_q  <= tx_data_d;
            ld_tx_q    <= ld_tx_d;
            par_cnt_q  <= par_cnt_d;
            addr_cnt_q <= addr_cnt_d;
            regs_q     <= regs_d;
        end
    end

    always_comb begin
        config_bits = '0;
        for (int unsigned i = 0; i < NUMREGS; i++) begin
            config_bits[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
        end
    end

    assign uld_rx_data    = (state_q == S_UNLOAD);
    assign busy           = (state_q != S_IDLE);
    assign tx_data        = tx_data_q;
    assign ld_tx_data     = ld_tx_q;
    assign parity_err_cnt = par_cnt_q;
    assign addr_err_cnt   = addr_cnt_q;

endmodule

// File: tb/tb_uart_regfile_ctrl.sv
// Bench for uart_regfile_ctrl: uart_rx/uart_tx models plus a packet-level reference model.
module tb_uart_regfile_ctrl;

    localparam int NR = 32;
    localparam int DW = 8;
    localparam int PW = 18;
    localparam int CW = NR * DW;
    localparam logic [CW-1:0] DEFAULTS =
        256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [PW-1:0] rx_data;
    logic          rx_empty;
    logic          uld_rx_data;
    logic [PW-1:0] tx_data;
    logic          ld_tx_data;
    logic          tx_busy;
    logic [CW-1:0] config_bits;
    logic [7:0]    parity_err_cnt;
    logic [7:0]    addr_err_cnt;
    logic          busy;

    always #5 clk = ~clk;

    uart_regfile_ctrl #(
        .NUMREGS(NR),
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(8),
        .REG_DEFAULTS(DEFAULTS),
        .ECHO_WRITES(1'b0)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .rx_data(rx_data),
        .rx_empty(rx_empty),
        .uld_rx_data(uld_rx_data),
        .tx_data(tx_data),
        .ld_tx_data(ld_tx_data),
        .tx_busy(tx_busy),
        .config_bits(config_bits),
        .parity_err_cnt(parity_err_cnt),
        .addr_err_cnt(addr_err_cnt),
        .busy(busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [DW-1:0] ref_regs [NR];
    int            ref_par;
    int            ref_addr;
    int            exp_ep = 0;
    logic [PW-1:0] rx_q [$];
    logic [PW-1:0] exp_q [$];
    bit            force_busy = 1'b0;
    bit            tx_mute = 1'b0;
    int            ep_cnt = 0;

    function automatic logic [PW-1:0] make_pkt(input logic [7:0] a, input logic [7:0] d,
                                               input logic w, input logic bad);
        logic [PW-2:0] body;
        logic          par;
        body = {a, d, w};
        par  = ($countones(body) % 2 == 0);
        if (bad) par = ~par;
        return {par, body};
    endfunction

    function automatic logic [CW-1:0] ref_config();
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < NR; i++) c[i*DW +: DW] = ref_regs[i];
        return c;
    endfunction

    task automatic model_reset();
        logic [CW-1:0] d;
        d = DEFAULTS;
        for (int i = 0; i < NR; i++) ref_regs[i] = d[i*DW +: DW];
        ref_par  = 0;
        ref_addr = 0;
        exp_q.delete();
    endtask

    task automatic model_apply(input logic [PW-1:0] p);
        int a;
        a = int'(p[16:9]);
        if ($countones(p) % 2 == 0) begin
            if (ref_par < 255) ref_par++;
        end else if (a >= NR) begin
            if (ref_addr < 255) ref_addr++;
        end else if (p[0] == 1'b0) begin
            ref_regs[a] = p[8:1];
        end else begin
            exp_q.push_back(make_pkt(p[16:9], ref_regs[a], 1'b1, 1'b0));
            exp_ep++;
        end
    endtask

    task automatic push_pkt(input logic [PW-1:0] p);
        rx_q.push_back(p);
        model_apply(p);
    endtask

    // uart_rx model: hands over the head packet the cycle after the unload strobe.
    initial begin : rx_model
        bit pend;
        rx_empty = 1'b1;
        rx_data  = '0;
        forever begin
            @(negedge clk);
            pend = uld_rx_data;
            @(posedge clk);
            #1;
            if (pend && rx_q.size() > 0) rx_data = rx_q.pop_front();
            rx_empty = (rx_q.size() == 0);
        end
    end

    // uart_tx model: accepts a load when idle, then stays busy for a few cycles.
    initial begin : tx_model
        int  busy_left;
        bit  prev_ld;
        busy_left = 0;
        prev_ld   = 1'b0;
        tx_busy   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ld_tx_data && !prev_ld) ep_cnt++;
            prev_ld = ld_tx_data;
            if (!reset_n) begin
                busy_left = 0;
            end else begin
                if (busy_left > 0) busy_left--;
                if (ld_tx_data && busy_left == 0 && !force_busy && !tx_mute) begin
                    check_val("reply_pending", CW'(exp_q.size() > 0), CW'(1));
                    if (exp_q.size() > 0) check_val("reply_pkt", CW'(tx_data), CW'(exp_q.pop_front()));
                    busy_left = $urandom_range(1, 4);
                end
            end
            tx_busy = force_busy || (busy_left > 0);
        end
    end

    task automatic drain(input int budget);
        int n;
        int quiet;
        n = 0;
        quiet = 0;
        while (quiet < 3 && n < budget) begin
            @(negedge clk);
            n++;
            if (rx_q.size() == 0 && rx_empty && !busy && !tx_busy) quiet++;
            else quiet = 0;
        end
        check_val("drain_done", CW'(quiet), CW'(3));
    endtask

    task automatic checkpoint(input string tag);
        check_val({tag, "_cfg"}, config_bits, ref_config());
        check_val({tag, "_parcnt"}, CW'(parity_err_cnt), CW'(ref_par));
        check_val({tag, "_addrcnt"}, CW'(addr_err_cnt), CW'(ref_addr));
        check_val({tag, "_replies_left"}, CW'(exp_q.size()), CW'(0));
        check_val({tag, "_ld_episodes"}, CW'(ep_cnt), CW'(exp_ep));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_cfg"}, config_bits, DEFAULTS);
        check_val({tag, "_parcnt"}, CW'(parity_err_cnt), CW'(0));
        check_val({tag, "_addrcnt"}, CW'(addr_err_cnt), CW'(0));
        check_val({tag, "_ld"}, CW'(ld_tx_data), CW'(0));
        check_val({tag, "_uld"}, CW'(uld_rx_data), CW'(0));
        check_val({tag, "_txdata"}, CW'(tx_data), CW'(0));
        check_val({tag, "_busy"}, CW'(busy), CW'(0));
    endtask

    initial begin : main
        int n;
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst_hold");
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_rel");

        // Write latency: reg1 <= AB visible after edge k+3, no reply
        push_pkt(make_pkt(8'h01, 8'hAB, 1'b0, 1'b0));
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_val("w_uld_k1", CW'(uld_rx_data), CW'(1));
        @(negedge clk);
        check_val("w_uld_k2", CW'(uld_rx_data), CW'(0));
        @(negedge clk);
        check_val("w_reg1_k2", CW'(config_bits[15:8]), CW'(8'h01));
        @(negedge clk);
        check_val("w_reg1_k3", CW'(config_bits[15:8]), CW'(8'hAB));
        drain(100);
        checkpoint("write1");

        // Read latency: ld_tx_data rises after edge k+4
        push_pkt(make_pkt(8'h01, 8'h00, 1'b1, 1'b0));
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_val("r_uld_k1", CW'(uld_rx_data), CW'(1));
        repeat (3) @(negedge clk);
        check_val("r_ld_k3", CW'(ld_tx_data), CW'(0));
        @(negedge clk);
        check_val("r_ld_k4", CW'(ld_tx_data), CW'(1));
        drain(100);
        push_pkt(make_pkt(8'h1F, 8'h00, 1'b1, 1'b0));
        drain(100);
        checkpoint("read");

        // Bad parity write: ignored, parity counter
        push_pkt(make_pkt(8'h05, 8'h3C, 1'b0, 1'b1));
        drain(100);
        check_val("par_reg5", CW'(config_bits[47:40]), CW'(8'h05));
        check_val("par_cnt1", CW'(parity_err_cnt), CW'(1));
        checkpoint("parity");

        // Out-of-range write and read
        push_pkt(make_pkt(8'h20, 8'h77, 1'b0, 1'b0));
        push_pkt(make_pkt(8'h20, 8'h00, 1'b1, 1'b0));
        drain(100);
        check_val("addr_cnt2", CW'(addr_err_cnt), CW'(2));
        checkpoint("addr");

        // tx_busy held high during a read reply with a write queued behind it
        force_busy = 1'b1;
        push_pkt(make_pkt(8'h01, 8'h00, 1'b1, 1'b0));
        push_pkt(make_pkt(8'h02, 8'h5A, 1'b0, 1'b0));
        repeat (50) @(negedge clk);
        check_val("hold_ld", CW'(ld_tx_data), CW'(0));
        check_val("hold_busy", CW'(busy), CW'(1));
        check_val("hold_reg2", CW'(config_bits[23:16]), CW'(8'h02));
        check_val("hold_queued", CW'(rx_q.size()), CW'(1));
        force_busy = 1'b0;
        drain(200);
        check_val("hold_reg2_after", CW'(config_bits[23:16]), CW'(8'h5A));
        checkpoint("hold");

        // Random traffic
        for (int i = 0; i < 100; i++) begin
            push_pkt(make_pkt(8'($urandom_range(0, 39)), 8'($urandom_range(0, 255)),
                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain(5000);
        checkpoint("random");

        // Reset while parked in TX_LOAD
        tx_mute = 1'b1;
        push_pkt(make_pkt(8'h03, 8'h00, 1'b1, 1'b0));
        n = 0;
        while (!ld_tx_data && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("txload_ld_seen", CW'(ld_tx_data), CW'(1));
        repeat (3) @(negedge clk);
        check_val("txload_ld_held", CW'(ld_tx_data), CW'(1));
        reset_n = 1'b0;
        #2;
        check_reset_outputs("txload_rst");
        model_reset();
        tx_mute = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        drain(100);
        checkpoint("post_rst");

        // Parity counter saturation
        for (int i = 0; i < 300; i++) begin
            push_pkt(make_pkt(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                              1'($urandom_range(0, 1)), 1'b1));
        end
        drain(4000);
        check_val("sat_parcnt", CW'(parity_err_cnt), CW'(255));
        check_val("sat_addrcnt", CW'(addr_err_cnt), CW'(0));
        checkpoint("sat");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
